// File: rtl/enemy_draw_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : draw_sched_pkg
// Description : Shared types and constants for the enemy draw scheduler.
//               ENEMY_COUNT  - number of enemy objects sharing the engine
//               enemy_id_t   - 2-bit enemy index (0..2)
//               sched_state_t- scheduler FSM state encoding
//               next_id()    - circular successor of an enemy index
// Revision    : 1.0 - initial release
// ============================================================================
package draw_sched_pkg;

    localparam int ENEMY_COUNT = 3;

    // Mirror the DAC width of vector_pkg and the ROM address width of img_pkg
    // so this block stays self-contained.
    localparam int DAC_WIDTH  = 8;
    localparam int ADDR_WIDTH = 16;

    typedef logic [1:0] enemy_id_t;

    localparam enemy_id_t c_LAST_ID = enemy_id_t'(ENEMY_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SELECT    = 3'd1,
        S_START     = 3'd2,
        S_WAIT      = 3'd3,
        S_FRAME_END = 3'd4
    } sched_state_t;

    // Circular successor: 0 -> 1 -> 2 -> 0.
    function automatic enemy_id_t next_id(input enemy_id_t id);
        return (id >= c_LAST_ID) ? enemy_id_t'(0) : enemy_id_t'(id + 2'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_draw_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Scans the 3-bit request
//               mask circularly starting at i_rr_ptr and returns the first
//               set position.
//   i_mask    in  3  request mask (bit n = enemy n)
//   i_rr_ptr  in  2  scan start position (0..2)
//   o_valid   out 1  at least one request present
//   o_id      out 2  chosen enemy (0 when o_valid is low)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import draw_sched_pkg::*;
(
    input  logic [ENEMY_COUNT-1:0] i_mask,
    input  enemy_id_t              i_rr_ptr,
    output logic                   o_valid,
    output enemy_id_t              o_id
);

    enemy_id_t w_c0;
    enemy_id_t w_c1;
    enemy_id_t w_c2;

    // An out-of-range pointer (3) is folded onto 0 so the scan never indexes
    // past the mask.
    assign w_c0 = (i_rr_ptr > c_LAST_ID) ? enemy_id_t'(0) : i_rr_ptr;
    assign w_c1 = next_id(w_c0);
    assign w_c2 = next_id(w_c1);

    always_comb begin
        o_valid = |i_mask;
        o_id    = enemy_id_t'(0);
        if (i_mask[w_c0]) begin
            o_id = w_c0;
        end else if (i_mask[w_c1]) begin
            o_id = w_c1;
        end else if (i_mask[w_c2]) begin
            o_id = w_c2;
        end
    end

endmodule
`default_nettype wire

// File: rtl/enemy_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : enemy_draw_scheduler
// Description : Time-shares the single vector draw engine between the three
//               enemy objects. Each frame_start draws every spawned enemy
//               once, round-robin, with a rotating start index.
//   clk, rst            clock / synchronous active-high reset
//   frame_start         pulse, begins a draw frame
//   spawn_enemyN        enemy N alive (N = 1..3)
//   xenemyN, adr_enemyN enemy N X position and sprite ROM base
//   draw_done           engine pulse, current sprite finished
//   draw_start          pulse, engine begins sprite
//   draw_x/adr/id       latched parameters of the sprite being drawn
//   busy                high in every state except IDLE
//   frame_done          pulse, frame finished
//   timeout_err         sticky, a draw was abandoned after TIMEOUT_CYCLES
//   frame_overrun       sticky, frame_start arrived while busy
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_draw_scheduler
    import draw_sched_pkg::*;
#(
    parameter int ADDRESSWIDTH   = ADDR_WIDTH,
    parameter int OUT_WIDTH      = DAC_WIDTH,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    spawn_enemy1,
    input  logic                    spawn_enemy2,
    input  logic                    spawn_enemy3,
    input  logic [OUT_WIDTH-1:0]    xenemy1,
    input  logic [OUT_WIDTH-1:0]    xenemy2,
    input  logic [OUT_WIDTH-1:0]    xenemy3,
    input  logic [ADDRESSWIDTH-1:0] adr_enemy1,
    input  logic [ADDRESSWIDTH-1:0] adr_enemy2,
    input  logic [ADDRESSWIDTH-1:0] adr_enemy3,
    input  logic                    draw_done,
    output logic                    draw_start,
    output logic [OUT_WIDTH-1:0]    draw_x,
    output logic [ADDRESSWIDTH-1:0] draw_adr,
    output enemy_id_t               draw_id,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    timeout_err,
    output logic                    frame_overrun
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    sched_state_t             r_state;
    sched_state_t             w_state_next;
    logic [ENEMY_COUNT-1:0]   r_pending;
    enemy_id_t                r_rr_ptr;
    logic [c_CNT_W-1:0]       r_wait_cnt;

    logic [ENEMY_COUNT-1:0]   w_spawn;
    logic [ENEMY_COUNT-1:0]   w_mask;
    logic                     w_valid;
    enemy_id_t                w_pick_id;
    logic [OUT_WIDTH-1:0]     w_pick_x;
    logic [ADDRESSWIDTH-1:0]  w_pick_adr;
    logic                     w_timeout;

    assign w_spawn = {spawn_enemy3, spawn_enemy2, spawn_enemy1};

    // Enemies that despawn mid-frame drop out of the candidate set.
    assign w_mask = r_pending & w_spawn;

    rr_pick u_rr_pick (
        .i_mask   (w_mask),
        .i_rr_ptr (r_rr_ptr),
        .o_valid  (w_valid),
        .o_id     (w_pick_id)
    );

    always_comb begin
        w_pick_x   = xenemy3;
        w_pick_adr = adr_enemy3;
        case (w_pick_id)
            2'd0: begin
                w_pick_x   = xenemy1;
                w_pick_adr = adr_enemy1;
            end
            2'd1: begin
                w_pick_x   = xenemy2;
                w_pick_adr = adr_enemy2;
            end
            default: begin
                w_pick_x   = xenemy3;
                w_pick_adr = adr_enemy3;
            end
        endcase
    end

    // Next-state logic. draw_done takes priority over the timeout so a done
    // that lands on the final counted cycle is not reported as an error.
    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_state_next = S_SELECT;
                end
            end
            S_SELECT: begin
                w_state_next = w_valid ? S_START : S_FRAME_END;
            end
            S_START: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (draw_done) begin
                    w_state_next = S_SELECT;
                end else if (r_wait_cnt == c_TIMEOUT_LAST) begin
                    w_state_next = S_SELECT;
                    w_timeout    = 1'b1;
                end
            end
            S_FRAME_END: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register plus registered outputs, which are decoded from the
    // next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pending     <= '0;
            r_rr_ptr      <= '0;
            r_wait_cnt    <= '0;
            draw_start    <= 1'b0;
            draw_x        <= '0;
            draw_adr      <= '0;
            draw_id       <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            timeout_err   <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            busy       <= (w_state_next != S_IDLE);
            draw_start <= (w_state_next == S_START);
            frame_done <= (w_state_next == S_FRAME_END);

            if ((r_state == S_IDLE) && frame_start) begin
                r_pending <= w_spawn;
            end

            if ((r_state == S_SELECT) && w_valid) begin
                draw_id              <= w_pick_id;
                draw_x               <= w_pick_x;
                draw_adr             <= w_pick_adr;
                r_pending[w_pick_id] <= 1'b0;
            end

            if (r_state == S_START) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (w_timeout) begin
                timeout_err <= 1'b1;
            end

            if (frame_start && (r_state != S_IDLE)) begin
                frame_overrun <= 1'b1;
            end

            if (r_state == S_FRAME_END) begin
                r_rr_ptr <= next_id(r_rr_ptr);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_enemy_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_enemy_draw_scheduler
// Description : Self-checking bench for enemy_draw_scheduler and rr_pick.
//               Frame-level reference model: expected draw order, draw
//               parameters and cycle offsets are derived from the spawn set,
//               the rotating start index and the engine latency per enemy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_draw_scheduler;
    import draw_sched_pkg::*;

    localparam int c_AW = 16;
    localparam int c_XW = 8;
    localparam int c_TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            frame_start;
    logic [2:0]      spawn;
    logic [c_XW-1:0] xs   [3];
    logic [c_AW-1:0] adrs [3];
    logic            draw_done;
    logic            draw_start;
    logic [c_XW-1:0] draw_x;
    logic [c_AW-1:0] draw_adr;
    enemy_id_t       draw_id;
    logic            busy;
    logic            frame_done;
    logic            timeout_err;
    logic            frame_overrun;

    logic [2:0]      pk_mask;
    enemy_id_t       pk_ptr;
    logic            pk_valid;
    enemy_id_t       pk_id;

    always #5 clk = ~clk;

    enemy_draw_scheduler #(
        .ADDRESSWIDTH   (c_AW),
        .OUT_WIDTH      (c_XW),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .spawn_enemy1  (spawn[0]),
        .spawn_enemy2  (spawn[1]),
        .spawn_enemy3  (spawn[2]),
        .xenemy1       (xs[0]),
        .xenemy2       (xs[1]),
        .xenemy3       (xs[2]),
        .adr_enemy1    (adrs[0]),
        .adr_enemy2    (adrs[1]),
        .adr_enemy3    (adrs[2]),
        .draw_done     (draw_done),
        .draw_start    (draw_start),
        .draw_x        (draw_x),
        .draw_adr      (draw_adr),
        .draw_id       (draw_id),
        .busy          (busy),
        .frame_done    (frame_done),
        .timeout_err   (timeout_err),
        .frame_overrun (frame_overrun)
    );

    rr_pick u_pick (
        .i_mask   (pk_mask),
        .i_rr_ptr (pk_ptr),
        .o_valid  (pk_valid),
        .o_id     (pk_id)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level model state
    int m_rr;
    bit m_timeout;
    bit m_overrun;

    typedef struct {
        logic [2:0] mask;
        logic [1:0] ptr;
        logic       valid;
        logic [1:0] id;
    } pick_vec_t;

    pick_vec_t vecs [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] ref_pick(input logic [2:0] mask, input int ptr);
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (ptr + k) % 3;
            if (mask[idx]) return {1'b1, 2'(idx)};
        end
        return 3'b000;
    endfunction

    function automatic int wait_len(input int lat);
        return (lat >= 1 && lat <= c_TO) ? lat : c_TO;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_draw_start"},    32'(draw_start), 0);
        check({tag, "_draw_x"},        32'(draw_x), 0);
        check({tag, "_draw_adr"},      32'(draw_adr), 0);
        check({tag, "_draw_id"},       32'(draw_id), 0);
        check({tag, "_busy"},          32'(busy), 0);
        check({tag, "_frame_done"},    32'(frame_done), 0);
        check({tag, "_timeout_err"},   32'(timeout_err), 0);
        check({tag, "_frame_overrun"}, 32'(frame_overrun), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_start = 1'b0;
        draw_done = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        m_rr = 0;
        m_timeout = 1'b0;
        m_overrun = 1'b0;
    endtask

    // lat = engine cycles from draw_start to draw_done (0 = never answers).
    // drop: spawn bits cleared once the first draw starts.
    // ovr : pulse frame_start in the first WAIT cycle.
    task automatic run_frame(input logic [2:0] sp, input int lat0, input int lat1,
                             input int lat2, input logic [2:0] drop, input bit ovr);
        int lat [3];
        int q [$];
        int exp_t;
        int cnt;
        int ovr_t;
        bit first;
        bit fin;
        lat = '{lat0, lat1, lat2};
        spawn = sp;
        for (int k = 0; k < 3; k++) begin
            int id;
            id = (m_rr + k) % 3;
            if (sp[id]) q.push_back(id);
        end
        exp_t = 2;
        cnt = 0;
        ovr_t = -1;
        first = 1'b0;
        fin = 1'b0;
        frame_start = 1'b1;
        for (int t = 1; t <= 400 && !fin; t++) begin
            tick();
            frame_start = (t == ovr_t);
            draw_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) draw_done = 1'b1;
            end
            check("busy_in_frame", 32'(busy), 1);
            if (draw_start) begin
                if (q.size() == 0) begin
                    check("unexpected_draw_start", 32'(draw_start), 0);
                end else begin
                    int id;
                    id = q.pop_front();
                    check("draw_id", 32'(draw_id), 32'(id));
                    check("draw_x", 32'(draw_x), 32'(xs[id]));
                    check("draw_adr", 32'(draw_adr), 32'(adrs[id]));
                    check("draw_start_cycle", 32'(t), 32'(exp_t));
                    exp_t += 2 + wait_len(lat[id]);
                    cnt = lat[id];
                    if (!(lat[id] >= 1 && lat[id] <= c_TO)) m_timeout = 1'b1;
                    if (!first) begin
                        first = 1'b1;
                        spawn = spawn & ~drop;
                        for (int j = q.size() - 1; j >= 0; j--)
                            if (drop[q[j]]) q.delete(j);
                        if (ovr) begin
                            ovr_t = t + 1;
                            m_overrun = 1'b1;
                        end
                    end
                end
            end
            if (frame_done) begin
                fin = 1'b1;
                check("frame_done_cycle", 32'(t), 32'(exp_t));
                check("draws_left", 32'(q.size()), 0);
            end
        end
        if (!fin) check("frame_done_seen", 0, 1);
        frame_start = 1'b0;
        draw_done = 1'b0;
        m_rr = (m_rr + 1) % 3;
        tick();
        check("busy_after_frame", 32'(busy), 0);
        check("frame_done_pulse", 32'(frame_done), 0);
        check("timeout_err", 32'(timeout_err), 32'(m_timeout));
        check("frame_overrun", 32'(frame_overrun), 32'(m_overrun));
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        draw_done = 1'b0;
        spawn = 3'b000;
        xs = '{8'h11, 8'h22, 8'h33};
        adrs = '{16'hA001, 16'hB002, 16'hC003};

        // rr_pick: all masks x all pointers
        for (int m = 0; m < 8; m++) begin
            for (int p = 0; p < 3; p++) begin
                logic [2:0] r;
                r = ref_pick(3'(m), p);
                vecs[m*3+p] = '{mask: 3'(m), ptr: 2'(p), valid: r[2], id: r[1:0]};
            end
        end
        for (int i = 0; i < 24; i++) begin
            pk_mask = vecs[i].mask;
            pk_ptr  = vecs[i].ptr;
            #1;
            check("pick_valid", 32'(pk_valid), 32'(vecs[i].valid));
            if (vecs[i].valid) check("pick_id", 32'(pk_id), 32'(vecs[i].id));
        end

        do_reset();

        // All spawned, two frames: order 0,1,2 then 1,2,0
        run_frame(3'b111, 10, 10, 10, 3'b000, 1'b0);
        run_frame(3'b111, 10, 10, 10, 3'b000, 1'b0);

        // Only enemy2
        xs[1] = 8'h40;
        adrs[1] = 16'h1234;
        run_frame(3'b010, 5, 5, 5, 3'b000, 1'b0);

        // Empty frame
        run_frame(3'b000, 5, 5, 5, 3'b000, 1'b0);

        // draw_done on the last counted cycle wins over the timeout
        run_frame(3'b001, c_TO, c_TO, c_TO, 3'b000, 1'b0);

        // Engine silent for enemy1 and enemy3
        run_frame(3'b111, 0, 3, 0, 3'b000, 1'b0);

        // enemy3 despawned during enemy1's draw
        do_reset();
        run_frame(3'b111, 6, 6, 6, 3'b100, 1'b0);

        // frame_start during WAIT
        run_frame(3'b111, 4, 4, 4, 3'b000, 1'b1);

        // rst during WAIT, then a stray draw_done
        spawn = 3'b001;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        check("rstwait_draw_start", 32'(draw_start), 1);
        tick();
        check("rstwait_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("rstwait");
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        repeat (3) tick();
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_draw_start", 32'(draw_start), 0);
        check("post_rst_frame_done", 32'(frame_done), 0);
        m_rr = 0;
        m_timeout = 1'b0;
        m_overrun = 1'b0;

        // Randomised frames
        do_reset();
        for (int f = 0; f < 40; f++) begin
            int l [3];
            logic [2:0] dr;
            for (int i = 0; i < 3; i++) begin
                xs[i]   = 8'($urandom);
                adrs[i] = 16'($urandom);
                l[i]    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 18));
            end
            dr = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            run_frame(3'($urandom_range(0, 7)), l[0], l[1], l[2], dr,
                      ($urandom_range(0, 4) == 0));
            repeat ($urandom_range(0, 3)) begin
                tick();
                check("idle_busy", 32'(busy), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
